// File: rtl/ro_freq_meter_if.sv
// Control/result bundle between the test controller and ro_freq_meter.
// RO_FREQ_METER_CONT_EN adds the continuous-mode request line.
interface ro_freq_meter_if #(
  parameter int GATE_W = 16,
  parameter int CNT_W  = 16
);
  logic              start;
  logic [GATE_W-1:0] gate_len;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  count;
  logic              ovf;
`ifdef RO_FREQ_METER_CONT_EN
  logic              cont;

  modport master (
    output start, gate_len, cont,
    input  busy, done, count, ovf
  );
  modport slave (
    input  start, gate_len, cont,
    output busy, done, count, ovf
  );
`else
  modport master (
    output start, gate_len,
    input  busy, done, count, ovf
  );
  modport slave (
    input  start, gate_len,
    output busy, done, count, ovf
  );
`endif
endinterface

// File: rtl/ro_freq_meter.sv
// Ring-oscillator edge counter over a programmable ck gate window.
// RO_FREQ_METER_CONT_EN enables back-to-back continuous windows.
module ro_freq_meter #(
  parameter int GATE_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic ck,
  input  logic nrst,
  input  logic ro_i,
  ro_freq_meter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEAS,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic s1, s2, s3;
  logic ro_rise;

  logic [GATE_W-1:0] gcnt;
  logic [CNT_W-1:0]  count_q;
  logic              ovf_q;

  logic              arm;
  logic [GATE_W-1:0] arm_len;

`ifdef RO_FREQ_METER_CONT_EN
  logic [GATE_W-1:0] glen_q;
`endif

  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= ro_i;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign ro_rise = s2 & ~s3;

  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // arm opens a new window, from IDLE or a continuous DONE
  always_comb begin
    state_d = state_q;
    arm     = 1'b0;
    arm_len = bus.gate_len;
    unique case (1'b1)
      state_q == S_IDLE: begin
        if (bus.start) arm = 1'b1;
      end
      state_q == S_MEAS: begin
        if (gcnt == '0) state_d = S_DONE;
      end
      state_q == S_DONE: begin
        state_d = S_IDLE;
`ifdef RO_FREQ_METER_CONT_EN
        arm_len = glen_q;
        if (bus.cont) arm = 1'b1;
`endif
      end
      default: state_d = S_IDLE;
    endcase
    if (arm) state_d = (arm_len == '0) ? S_DONE : S_MEAS;
  end

  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      gcnt    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (arm) begin
      gcnt    <= (arm_len == '0) ? '0 : arm_len - 1'b1;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (state_q == S_MEAS) begin
      if (ro_rise) begin
        if (&count_q) ovf_q   <= 1'b1;
        else          count_q <= count_q + 1'b1;
      end
      if (gcnt != '0) gcnt <= gcnt - 1'b1;
    end
  end

`ifdef RO_FREQ_METER_CONT_EN
  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst)                           glen_q <= '0;
    else if (state_q == S_IDLE && bus.start) glen_q <= bus.gate_len;
  end
`endif

  assign bus.busy  = (state_q == S_MEAS);
  assign bus.done  = (state_q == S_DONE);
  assign bus.count = count_q;
  assign bus.ovf   = ovf_q;

endmodule

// File: doc/ro_freq_meter.md
# ro_freq_meter

Synchronous frequency meter for the library's ring-oscillator characterisation structure, a chain of `inv_x0` cells closed into a loop. It sits directly downstream of the inverter chain. It takes the free-running oscillator tap as an asynchronous input, synchronises it into the `ck` domain, and counts its rising edges over a programmable gate window of `ck` cycles. The resulting count is handed to the test controller, which uses it to derive per-stage inverter delay.

## Interface

Parameters:
- `GATE_W`, default 16: width of the gate-window length.
- `CNT_W`, default 16: width of the edge counter.

Ports:
- `ck` in, 1: clock. Rising edge.
- `nrst` in, 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `start` in, 1: single-cycle request to begin a measurement. Honoured only in IDLE.
- `gate_len` in, `GATE_W`: window length in `ck` cycles. Sampled on an accepted `start`.
- `ro_i` in, 1: ring-oscillator tap. Asynchronous to `ck`.
- `busy` out, 1: high while in MEAS.
- `done` out, 1: one-cycle pulse when the result is valid.
- `count` out, `CNT_W`: rising edges counted in the last window. Held until the next accepted `start`.
- `ovf` out, 1: sticky; set when the counter saturated in the last window.
- `cont` in, 1: continuous-mode request. Present only with `RO_FREQ_METER_CONT_EN`.

## Operation

- Synchroniser and edge detector:
  - Flops `s1 -> s2 -> s3` sample `ro_i`, all reset to 0.
  - Rising edge is `edge = s2 & ~s3`.
- FSM states: IDLE, MEAS, DONE. Reset state is IDLE.
- IDLE:
  - On `start`, clear `count` and `ovf` and latch `gate_len` into the gate down-counter `gcnt`.
  - If `gate_len == 0`, go to DONE. Otherwise go to MEAS with `gcnt = gate_len - 1`.
- MEAS:
  - Each cycle, if `edge`, then `count <= count + 1`. If `count` is all ones, `count` holds and `ovf <= 1` (saturating).
  - If `gcnt == 0`, go to DONE. Otherwise `gcnt <= gcnt - 1`.
- DONE:
  - Assert `done` for exactly one cycle, then return to IDLE.
- `start` in MEAS or DONE is ignored. No queuing.
- Reset values: `busy = 0`, `done = 0`, `count = 0`, `ovf = 0`, `gcnt = 0`, synchroniser flops 0.
- Asynchronous reset mid-window aborts immediately to IDLE with all values above. No `done` is produced.
- Accuracy requirement on the source: `ro_i` high and low phases each ≥ 2 `ck` periods. Faster inputs undercount; this is documented, not detected.

## Timing

- `ro_i` edge to `count` increment: 3 `ck` edges (2 synchroniser stages plus 1 edge flop), provided the window is still open.
- MEAS lasts exactly `gate_len` cycles. Edges detected in those cycles are counted; edges in the IDLE or DONE cycles are not.
- `start` sampled at edge N:
  - `busy` is high from N+1 through N+`gate_len`.
  - `done` is high at N+`gate_len`+1.
  - `count` is final and stable when `done` is high.
- `gate_len == 0`: `done` at N+1, `count = 0`, `busy` never asserts.
- Next `start` is accepted at the cycle following `done`, back in IDLE.

## Configuration

- `RO_FREQ_METER_CONT_EN` defined:
  - Port `cont` exists.
  - If `cont` is high in the DONE cycle, the FSM goes from DONE back to MEAS with the previously latched `gate_len`, instead of to IDLE.
  - In that case `count`/`ovf` clear in the transition cycle. `done` still pulses once per window.
  - `gate_len` 0 in continuous mode: repeated DONE, pulsing `done` every cycle with `count = 0`.
- `RO_FREQ_METER_CONT_EN` undefined:
  - No `cont` port.
  - DONE always returns to IDLE; single-shot only.

## Test plan

- Reset:
  - Assert `nrst` low with `ro_i` toggling → `busy = 0`, `done = 0`, `count = 0`, `ovf = 0`.
  - After release, with no `start`, outputs unchanged for 100 cycles.
- Basic count:
  - `gate_len = 64`, `ro_i` low at `start`, then 7 pulses (2 cycles high, 2 low) beginning cycle 5 of the window → `done` at N+65, `count = 7`, `ovf = 0`.
- Saturation:
  - `CNT_W = 4`, `gate_len = 100`, 20 pulses → `count = 15`, `ovf = 1`.
  - Next `start` clears both.
- Zero window and ignored `start`:
  - `gate_len = 0` → `done` at N+1, `count = 0`.
  - `start` re-pulsed during MEAS of a 50-cycle window → single `done` at N+51.
- Reset mid-window:
  - `nrst` low at window cycle 20 → outputs at reset values immediately. No `done`.
  - A new `start` after release measures normally.
- Continuous mode (`RO_FREQ_METER_CONT_EN`):
  - `cont = 1`, `gate_len = 32`, steady input period 8 → `done` at N+33, N+66, N+99. Each `count` is 4.
  - Dropping `cont` before the third DONE returns the FSM to IDLE.
